generic_array_store: RTL

Synthesizable, parametrised successor to the class-based generic array container: an indexed, append-ordered storage block with width, depth and overflow mode set by parameters. Elements are appended through a valid/ready port and read back by logical index (0 = oldest) with fixed one-cycle latency. Out-of-range reads are flagged, and a clear operation empties the store. It sits between a producer streaming records and a consumer needing random access to the retained history, such as a scoreboard or trace buffer.

---
 rtl/generic_store_pkg.sv | 25 ++
 rtl/generic_store_mem.sv | 35 +++
 rtl/generic_array_store.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/generic_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : generic_store_pkg
//  Purpose  : Shared constants and helpers for generic_array_store.
//             - MODE_REJECT / MODE_OVERWRITE overflow policy encodings
//             - wrap_add(): (a + b) mod depth by compare-subtract, valid for
//               a < depth and b <= depth, so no power-of-two depth is assumed
//  Revision : 1.0  initial release
// ============================================================================
package generic_store_pkg;

   localparam int MODE_REJECT    = 0;
   localparam int MODE_OVERWRITE = 1;

   function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] depth);
      logic [31:0] s;
      s = a + b;
      if (s >= depth) s = s - depth;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/generic_store_mem.sv
`default_nettype none
// ============================================================================
//  Module   : generic_store_mem
//  Purpose  : Simple dual-port RAM, DATA_W x DEPTH, one write port and one
//             registered read port. A read and a write to the same slot on
//             the same edge return the old contents.
//  Ports    : clk                  - clock, rising edge
//             i_we/i_waddr/i_wdata - write port
//             i_re/i_raddr         - read request, address
//             o_rdata              - read data, valid the cycle after i_re
//  Revision : 1.0  initial release
// ============================================================================
module generic_store_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/generic_array_store.sv
`default_nettype none
// ============================================================================
//  Module   : generic_array_store
//  Purpose  : Append-ordered indexed store. Elements enter through a
//             valid/ready port and are read back by logical index
//             (0 = oldest) with one-cycle latency. MODE selects reject-when-
//             full or overwrite-oldest. Optional macro
//             GENERIC_ARRAY_STORE_ERRCNT_EN adds a saturating 16-bit count
//             of out-of-range read results (o_err_count).
//  Ports    : clk, rst_n (async, active-low)
//             i_add_valid, i_add_data, o_add_ready  - append port
//             i_rd_en, i_rd_idx                     - read request
//             o_rd_valid, o_rd_data, o_rd_err       - read result (+1 cycle)
//             i_clear                               - synchronous empty
//             o_count, o_empty, o_full, o_overflow  - status
//             o_err_count (macro only)              - error read counter
//  Revision : 1.0  initial release
// ============================================================================
module generic_array_store
   import generic_store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int MODE   = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_add_valid,
   input  logic [DATA_W-1:0]          i_add_data,
   output logic                       o_add_ready,
   input  logic                       i_rd_en,
   input  logic [$clog2(DEPTH+1)-1:0] i_rd_idx,
   output logic                       o_rd_valid,
   output logic [DATA_W-1:0]          o_rd_data,
   output logic                       o_rd_err,
   input  logic                       i_clear,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_overflow
`ifdef GENERIC_ARRAY_STORE_ERRCNT_EN
   ,
   output logic [15:0]                o_err_count
`endif
);

   localparam int   CNT_W  = $clog2(DEPTH+1);
   localparam int   PTR_W  = $clog2(DEPTH);
   localparam logic OVR_EN = (MODE == MODE_OVERWRITE);

   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_head;
   logic              r_overflow;
   logic              r_rd_valid;
   logic              r_rd_err;

   logic              w_full;
   logic              w_accept;
   logic              w_rd_oor;
   logic [PTR_W-1:0]  w_wr_slot;
   logic [PTR_W-1:0]  w_rd_slot;
   logic [PTR_W-1:0]  w_head_nxt;
   logic [DATA_W-1:0] w_mem_rdata;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   // add_ready depends on clear and state only, never on add_valid.
   assign o_add_ready = !i_clear && (!w_full || OVR_EN);
   assign w_accept    = i_add_valid && o_add_ready;

   // When full, head + count wraps back onto head: the overwrite slot.
   assign w_wr_slot  = PTR_W'(wrap_add(32'(r_head), 32'(r_count), 32'(DEPTH)));
   assign w_head_nxt = PTR_W'(wrap_add(32'(r_head), 32'd1, 32'(DEPTH)));

   // Out-of-range indices are parked on slot 0 so the RAM is never
   // addressed outside its depth; the result is masked anyway.
   assign w_rd_oor  = (i_rd_idx >= r_count);
   assign w_rd_slot = w_rd_oor ? '0
                    : PTR_W'(wrap_add(32'(r_head), 32'(i_rd_idx), 32'(DEPTH)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_head     <= '0;
         r_overflow <= 1'b0;
      end else if (i_clear) begin
         r_count    <= '0;
         r_head     <= '0;
         r_overflow <= 1'b0;
      end else if (w_accept && w_full) begin
         r_head     <= w_head_nxt;
         r_overflow <= 1'b1;
      end else if (w_accept) begin
         r_count    <= r_count + CNT_W'(1);
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         r_rd_err   <= i_rd_en && w_rd_oor;
      end
   end

   // The RAM read and write share an edge, so a read of the slot being
   // overwritten returns the pre-overwrite element.
   generic_store_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_accept),
      .i_waddr (w_wr_slot),
      .i_wdata (i_add_data),
      .i_re    (i_rd_en && !w_rd_oor),
      .i_raddr (w_rd_slot),
      .o_rdata (w_mem_rdata)
   );

   assign o_rd_valid = r_rd_valid;
   assign o_rd_err   = r_rd_err;
   assign o_rd_data  = (r_rd_valid && !r_rd_err) ? w_mem_rdata : '0;
   assign o_count    = r_count;
   assign o_empty    = (r_count == '0);
   assign o_full     = w_full;
   assign o_overflow = r_overflow;

`ifdef GENERIC_ARRAY_STORE_ERRCNT_EN
   logic [15:0] r_err_count;

   // Only rst_n clears the error history; i_clear deliberately does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_count <= '0;
      else if (r_rd_err && (r_err_count != 16'hFFFF))
         r_err_count <= r_err_count + 16'd1;
   end

   assign o_err_count = r_err_count;
`endif

endmodule
`default_nettype wire
